// File: rtl/mem_wb_stage.sv
// mem_wb_stage: consumer end of the EX/MEM register.
// Resolves taken branches combinationally, runs loads/stores over a req/ack
// data-memory handshake (stalling upstream while the access is outstanding,
// aborting after TIMEOUT request cycles), and holds the MEM/WB register that
// feeds register-file writeback.
module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid_in,
  input  logic              mem_memtoreg_in,
  input  logic              mem_regwrite_in,
  input  logic              mem_memread_in,
  input  logic              mem_memwrite_in,
  input  logic              mem_branch_in,
  input  logic              mem_zero_in,
  input  logic [DATA_W-1:0] mem_add_in,
  input  logic [DATA_W-1:0] mem_alures_in,
  input  logic [DATA_W-1:0] mem_rd2_in,
  input  logic [RF_AW-1:0]  mem_rd_in,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [RF_AW-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  // Counter must reach TIMEOUT-1; at least one bit even for TIMEOUT==2.
  localparam int CNT_W = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_dm_req;
  logic                r_dm_we;
  logic [DATA_W-1:0]   r_dm_addr;
  logic [DATA_W-1:0]   r_dm_wdata;
  logic                r_err;
  logic                r_wb_valid;
  logic                r_wb_regwrite;
  logic [RF_AW-1:0]    r_wb_rd;
  logic [DATA_W-1:0]   r_wb_data;

  logic                w_memop;
  logic                w_in_req;
  logic                w_cnt_last;
  logic                w_abort;
  logic                w_stall;
  logic                w_sel_load;

  // Handshake decode: an access finishes on ack, or aborts on the last counted cycle without ack.
  always_comb begin
    w_memop    = mem_valid_in & (mem_memread_in | mem_memwrite_in);
    w_in_req   = (r_state == S_REQ);
    w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));
    w_abort    = w_in_req & ~dm_ack & w_cnt_last;
    w_stall    = w_memop & ~(w_in_req & (dm_ack | w_cnt_last));
    // A store always wins over a simultaneous load flag, so only pure loads return memory data.
    w_sel_load = mem_memread_in & ~mem_memwrite_in & mem_memtoreg_in;
  end

  // Memory-access FSM with registered request outputs and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_memop) begin
            r_state    <= S_REQ;
            r_cnt      <= '0;
            r_dm_req   <= 1'b1;
            r_dm_we    <= mem_memwrite_in;
            r_dm_addr  <= mem_alures_in;
            r_dm_wdata <= mem_rd2_in;
          end
        end
        S_REQ: begin
          if (dm_ack) begin
            r_state  <= S_IDLE;
            r_dm_req <= 1'b0;
          end else if (w_cnt_last) begin
            r_state  <= S_IDLE;
            r_dm_req <= 1'b0;
            r_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_dm_req <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, otherwise retire the EX/MEM entry (killed on abort).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid    <= 1'b0;
      r_wb_regwrite <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_data     <= '0;
    end else if (w_stall) begin
      r_wb_valid    <= 1'b0;
      r_wb_regwrite <= 1'b0;
    end else begin
      r_wb_valid    <= mem_valid_in & ~w_abort;
      r_wb_regwrite <= mem_valid_in & mem_regwrite_in & (mem_rd_in != '0) & ~w_abort;
      r_wb_rd       <= mem_rd_in;
      r_wb_data     <= w_sel_load ? dm_rdata : mem_alures_in;
    end
  end

  assign dm_req      = r_dm_req;
  assign dm_we       = r_dm_we;
  assign dm_addr     = r_dm_addr;
  assign dm_wdata    = r_dm_wdata;
  assign err         = r_err;
  assign stall       = w_stall;
  assign pc_src      = mem_valid_in & mem_branch_in & mem_zero_in;
  assign pc_target   = mem_add_in;
  assign wb_valid    = r_wb_valid;
  assign wb_regwrite = r_wb_regwrite;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vectors for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_valid_in, mem_memtoreg_in, mem_regwrite_in;
  logic          mem_memread_in, mem_memwrite_in, mem_branch_in, mem_zero_in;
  logic [DW-1:0] mem_add_in, mem_alures_in, mem_rd2_in;
  logic [AW-1:0] mem_rd_in;
  logic          dm_req, dm_we;
  logic [DW-1:0] dm_addr, dm_wdata, dm_rdata;
  logic          dm_ack;
  logic          stall, pc_src;
  logic [DW-1:0] pc_target;
  logic          wb_valid, wb_regwrite;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          err;

  int n_cmp = 0;
  int n_err = 0;

  mem_wb_stage #(.DATA_W(DW), .RF_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .mem_valid_in(mem_valid_in), .mem_memtoreg_in(mem_memtoreg_in),
    .mem_regwrite_in(mem_regwrite_in), .mem_memread_in(mem_memread_in),
    .mem_memwrite_in(mem_memwrite_in), .mem_branch_in(mem_branch_in),
    .mem_zero_in(mem_zero_in), .mem_add_in(mem_add_in),
    .mem_alures_in(mem_alures_in), .mem_rd2_in(mem_rd2_in), .mem_rd_in(mem_rd_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall),
    .pc_src(pc_src), .pc_target(pc_target),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; registered outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    mem_valid_in = 0; mem_memtoreg_in = 0; mem_regwrite_in = 0;
    mem_memread_in = 0; mem_memwrite_in = 0; mem_branch_in = 0; mem_zero_in = 0;
    mem_add_in = '0; mem_alures_in = '0; mem_rd2_in = '0; mem_rd_in = '0;
    dm_ack = 0; dm_rdata = '0;
  endtask

  initial begin
    clr_in();
    reset = 1;
    tick(); tick();
    chk("rst_dm_req", dm_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    reset = 0;

    // 1: ALU op retires next cycle without stall
    mem_valid_in = 1; mem_regwrite_in = 1; mem_rd_in = 5; mem_alures_in = 32'h1234;
    #1 chk("alu_stall", stall, 0);
    tick();
    clr_in();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_regwrite", wb_regwrite, 1);
    chk("alu_wb_rd", wb_rd, 5);
    chk("alu_wb_data", wb_data, 32'h1234);

    // 2: load, ack on the third cycle after request issue -> three stall cycles
    mem_valid_in = 1; mem_memread_in = 1; mem_memtoreg_in = 1; mem_regwrite_in = 1;
    mem_rd_in = 7; mem_alures_in = 32'h40;
    #1 chk("ld_stall0", stall, 1);
    chk("ld_req_before", dm_req, 0);
    tick();
    chk("ld_dm_req", dm_req, 1);
    chk("ld_dm_we", dm_we, 0);
    chk("ld_dm_addr", dm_addr, 32'h40);
    chk("ld_stall1", stall, 1);
    chk("ld_bubble", wb_valid, 0);
    tick();
    chk("ld_stall2", stall, 1);
    tick();
    dm_ack = 1; dm_rdata = 32'hDEADBEEF;
    #1 chk("ld_stall_ack", stall, 0);
    tick();
    clr_in();
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_rd", wb_rd, 7);
    chk("ld_wb_regwrite", wb_regwrite, 1);
    chk("ld_req_done", dm_req, 0);
    #1 chk("ld_after_stall", stall, 0);

    // 3: store with load flag also set; store wins, immediate ack
    mem_valid_in = 1; mem_memwrite_in = 1; mem_memread_in = 1; mem_memtoreg_in = 1;
    mem_alures_in = 32'h80; mem_rd2_in = 32'hCAFE0001; mem_rd_in = 3;
    dm_rdata = 32'h5555AAAA;
    #1 chk("st_stall0", stall, 1);
    tick();
    chk("st_dm_we", dm_we, 1);
    chk("st_dm_addr", dm_addr, 32'h80);
    chk("st_dm_wdata", dm_wdata, 32'hCAFE0001);
    dm_ack = 1;
    #1 chk("st_stall_ack", stall, 0);
    tick();
    clr_in();
    chk("st_wb_regwrite", wb_regwrite, 0);
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_data", wb_data, 32'h80);

    // 4: branch resolution is combinational
    mem_valid_in = 1; mem_branch_in = 1; mem_zero_in = 1; mem_add_in = 32'h100;
    #1 chk("br_pc_src", pc_src, 1);
    chk("br_pc_target", pc_target, 32'h100);
    chk("br_stall", stall, 0);
    mem_zero_in = 0;
    #1 chk("br_nz_pc_src", pc_src, 0);
    mem_zero_in = 1; mem_valid_in = 0;
    #1 chk("br_inv_pc_src", pc_src, 0);
    clr_in();

    // 5: load with no ack -> abort after TO request cycles
    mem_valid_in = 1; mem_memread_in = 1; mem_memtoreg_in = 1; mem_regwrite_in = 1;
    mem_rd_in = 9; mem_alures_in = 32'h44;
    #1 chk("to_stall0", stall, 1);
    tick();
    chk("to_dm_req", dm_req, 1);
    for (int i = 0; i < TO - 1; i++) begin
      chk($sformatf("to_stall_c%0d", i), stall, 1);
      tick();
    end
    chk("to_stall_rel", stall, 0);
    chk("to_req_last", dm_req, 1);
    chk("to_err_pre", err, 0);
    tick();
    clr_in();
    chk("to_dm_req_off", dm_req, 0);
    chk("to_err", err, 1);
    chk("to_wb_valid", wb_valid, 0);
    chk("to_wb_regwrite", wb_regwrite, 0);
    tick();
    chk("to_err_sticky", err, 1);

    // 6: reset mid-request, then a stray ack
    mem_valid_in = 1; mem_memread_in = 1; mem_regwrite_in = 1; mem_rd_in = 4;
    mem_alures_in = 32'h55;
    tick();
    chk("rs_dm_req", dm_req, 1);
    tick();
    reset = 1;
    clr_in();
    tick();
    reset = 0;
    dm_ack = 1; dm_rdata = 32'hFFFF;
    #1 chk("rs_stall", stall, 0);
    tick();
    dm_ack = 0; dm_rdata = '0;
    chk("rs_dm_req", dm_req, 0);
    chk("rs_dm_we", dm_we, 0);
    chk("rs_dm_addr", dm_addr, 0);
    chk("rs_dm_wdata", dm_wdata, 0);
    chk("rs_wb_valid", wb_valid, 0);
    chk("rs_wb_regwrite", wb_regwrite, 0);
    chk("rs_wb_rd", wb_rd, 0);
    chk("rs_wb_data", wb_data, 0);
    chk("rs_err", err, 0);
    chk("rs_pc_src", pc_src, 0);
    chk("rs_pc_target", pc_target, 0);
    // Back in IDLE: an ack alongside a new memop must not end the stall
    mem_valid_in = 1; mem_memread_in = 1; dm_ack = 1;
    #1 chk("rs_idle_ack_ignored", stall, 1);
    clr_in();
    #1;

    // rd=0 never writes the register file
    mem_valid_in = 1; mem_regwrite_in = 1; mem_rd_in = 0; mem_alures_in = 32'h77;
    tick();
    clr_in();
    chk("r0_wb_regwrite", wb_regwrite, 0);
    chk("r0_wb_valid", wb_valid, 1);
    chk("r0_wb_data", wb_data, 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
